// File: rtl/opsum_writeback_controller_if.sv
// Opsum FIFO read side and GLB write bus shared by the writeback controller
// (master) and the FIFO/GLB side (slave).
interface opsum_writeback_controller_if #(
    parameter int NUM_COL = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_COL-1:0]             opsum_fifo_empty;
    logic [NUM_COL-1:0]             opsum_pop_en;
    logic [NUM_COL-1:0][DATA_W-1:0] opsum_pop_data;
    logic                           glb_we_o;
    logic [31:0]                    glb_addr_o;
    logic [DATA_W-1:0]              glb_wdata_o;
    logic                           glb_ready_i;

    modport master (
        input  opsum_fifo_empty,
        input  opsum_pop_data,
        input  glb_ready_i,
        output opsum_pop_en,
        output glb_we_o,
        output glb_addr_o,
        output glb_wdata_o
    );

    modport slave (
        output opsum_fifo_empty,
        output opsum_pop_data,
        output glb_ready_i,
        input  opsum_pop_en,
        input  glb_we_o,
        input  glb_addr_o,
        input  glb_wdata_o
    );
endinterface

// File: rtl/opsum_writeback_controller.sv
// Drains per-column opsum FIFOs round-robin into the GLB opsum region,
// one 32-bit GLB write per popped entry, started once per pass.
module opsum_writeback_controller #(
    parameter int NUM_COL = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_start_i,
    output logic                         wb_done_o,
    input  logic [31:0]                  opsum_GLB_base_addr,
    input  logic [CNT_W-1:0]             tile_n_i,
    input  logic [6:0]                   OC_real_i,
    opsum_writeback_controller_if.master bus
);
    localparam int COL_W = $clog2(NUM_COL);
    localparam int OC_W  = COL_W + 1;
    localparam int IDX_W = OC_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_POP   = 3'd2,
        ST_CAP   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [CNT_W-1:0]    tile_q, tile_d;
    logic [OC_W-1:0]     oc_q, oc_d;
    logic [COL_W-1:0]    ptr_q, ptr_d;
    logic [COL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q [NUM_COL];
    logic [CNT_W-1:0]    cnt_d [NUM_COL];
    logic [NUM_COL-1:0]  pop_en_q, pop_en_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;

    logic [OC_W-1:0]     oc_clamp_s;
    logic                found_s;
    logic [COL_W-1:0]    hit_col_s;
    logic                all_done_s;
    logic [31:0]         addr_calc_s;
    logic [OC_W-1:0]     sel_plus_s;
    logic [COL_W-1:0]    next_ptr_s;

    assign oc_clamp_s  = (OC_real_i > 7'(NUM_COL)) ? OC_W'(NUM_COL) : OC_W'(OC_real_i);
    assign addr_calc_s = base_q + ((32'(sel_q) * 32'(tile_q) + 32'(cnt_q[sel_q])) << 2'd2);
    assign sel_plus_s  = OC_W'(sel_q) + OC_W'(1);
    assign next_ptr_s  = (sel_plus_s >= oc_q) ? '0 : sel_plus_s[COL_W-1:0];

    // Round-robin search for the first poppable column, starting at ptr and wrapping at OC_real.
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        logic             take_v;
        found_s   = 1'b0;
        hit_col_s = '0;
        idx_v     = '0;
        take_v    = 1'b0;
        for (int i = 0; i < NUM_COL; i++) begin
            idx_v     = IDX_W'(ptr_q) + IDX_W'(i);
            idx_v     = (idx_v >= IDX_W'(oc_q)) ? (idx_v - IDX_W'(oc_q)) : idx_v;
            take_v    = !found_s && (i < int'(oc_q))
                        && !bus.opsum_fifo_empty[idx_v[COL_W-1:0]]
                        && (cnt_q[idx_v[COL_W-1:0]] < tile_q);
            hit_col_s = take_v ? idx_v[COL_W-1:0] : hit_col_s;
            found_s   = found_s | take_v;
        end
    end

    // Completion test assuming the write currently held for sel is accepted this cycle.
    always_comb begin
        logic [CNT_W-1:0] cnt_after_v;
        all_done_s  = 1'b1;
        cnt_after_v = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            cnt_after_v = (COL_W'(c) == sel_q) ? (cnt_q[c] + CNT_W'(1)) : cnt_q[c];
            all_done_s  = all_done_s & ((c >= int'(oc_q)) | (cnt_after_v == tile_q));
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        tile_d   = tile_q;
        oc_d     = oc_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        pop_en_d = '0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (wb_start_i) begin
                    base_d = opsum_GLB_base_addr;
                    tile_d = tile_n_i;
                    oc_d   = oc_clamp_s;
                    ptr_d  = '0;
                    sel_d  = '0;
                    for (int c = 0; c < NUM_COL; c++) begin
                        cnt_d[c] = '0;
                    end
                    if ((oc_clamp_s == '0) || (tile_n_i == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (found_s) begin
                    sel_d    = hit_col_s;
                    pop_en_d = {{(NUM_COL-1){1'b0}}, 1'b1} << hit_col_s;
                    state_d  = ST_POP;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_POP: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // FIFO head data is valid the cycle after the pop strobe.
                wdata_d = bus.opsum_pop_data[sel_q];
                addr_d  = addr_calc_s;
                we_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.glb_ready_i) begin
                    cnt_d[sel_q] = cnt_q[sel_q] + CNT_W'(1);
                    ptr_d        = next_ptr_s;
                    we_d         = 1'b0;
                    if (all_done_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            tile_q   <= '0;
            oc_q     <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            pop_en_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            for (int c = 0; c < NUM_COL; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            tile_q   <= tile_d;
            oc_q     <= oc_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            pop_en_q <= pop_en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb_done_o        = done_q;
    assign bus.opsum_pop_en = pop_en_q;
    assign bus.glb_we_o     = we_q;
    assign bus.glb_addr_o   = addr_q;
    assign bus.glb_wdata_o  = wdata_q;

endmodule

// File: tb/tb_opsum_writeback_controller.sv
// Directed bench for opsum_writeback_controller with a behavioural FIFO/GLB model.
module tb_opsum_writeback_controller;
    localparam int NUM_COL = 32;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             wb_start_i = 1'b0;
    logic             wb_done_o;
    logic [31:0]      base_i     = 32'd0;
    logic [CNT_W-1:0] tile_n_i   = 16'd0;
    logic [6:0]       oc_real_i  = 7'd0;

    int n_cmp = 0;
    int n_mis = 0;

    // FIFO model: pops[] counts strobes, load_cnt[] total entries ever loaded.
    int unsigned pops     [NUM_COL] = '{default: 32'd0};
    int unsigned load_cnt [NUM_COL] = '{default: 32'd0};
    int unsigned val0     [NUM_COL] = '{default: 32'd0};
    int unsigned pop_snap [NUM_COL] = '{default: 32'd0};
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int unsigned wr_n     = 0;
    int unsigned done_cnt = 0;
    int unsigned bad_pop  = 0;
    int unsigned snap_wr  = 0;
    int unsigned snap_done = 0;
    int lat;
    int unsigned sum;

    opsum_writeback_controller_if #(.NUM_COL(NUM_COL), .DATA_W(DATA_W)) bus_if ();

    opsum_writeback_controller #(
        .NUM_COL(NUM_COL), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wb_start_i          (wb_start_i),
        .wb_done_o           (wb_done_o),
        .opsum_GLB_base_addr (base_i),
        .tile_n_i            (tile_n_i),
        .OC_real_i           (oc_real_i),
        .bus                 (bus_if.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NUM_COL; c++) begin
            bus_if.opsum_fifo_empty[c] = (pops[c] >= load_cnt[c]);
            bus_if.opsum_pop_data[c]   = val0[c] + pops[c] - 32'd1;
        end
    end

    always @(negedge clk) begin
        if (bus_if.glb_we_o && bus_if.glb_ready_i && (wr_n < 64)) begin
            wr_addr[wr_n] <= bus_if.glb_addr_o;
            wr_data[wr_n] <= bus_if.glb_wdata_o;
            wr_n          <= wr_n + 1;
        end
        if (wb_done_o) done_cnt <= done_cnt + 1;
        if (($countones(bus_if.opsum_pop_en) > 1)
            || ((bus_if.opsum_pop_en & bus_if.opsum_fifo_empty) != '0)
            || ((bus_if.opsum_pop_en != '0) && bus_if.glb_we_o))
            bad_pop <= bad_pop + 1;
        for (int c = 0; c < NUM_COL; c++) begin
            if (bus_if.opsum_pop_en[c]) pops[c] <= pops[c] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int c, input int n, input logic [31:0] first);
        load_cnt[c] = pops[c] + n;
        val0[c]     = first - pops[c];
    endtask

    task automatic clear_all();
        for (int c = 0; c < NUM_COL; c++) load_cnt[c] = pops[c];
    endtask

    task automatic snap();
        snap_wr   = wr_n;
        snap_done = done_cnt;
        for (int c = 0; c < NUM_COL; c++) pop_snap[c] = pops[c];
    endtask

    task automatic pulse_start();
        wb_start_i = 1'b1;
        step();
        wb_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, inout int n);
        while ((wb_done_o !== 1'b1) && (n < budget)) begin
            step();
            n++;
        end
    endtask

    task automatic wait_we(input int budget);
        int n = 0;
        while ((bus_if.glb_we_o !== 1'b1) && (n < budget)) begin
            step();
            n++;
        end
    endtask

    task automatic check_wr(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
        check($sformatf("%s_addr%0d", tag, k), wr_addr[snap_wr + k], a);
        check($sformatf("%s_data%0d", tag, k), wr_data[snap_wr + k], d);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    32'(bus_if.glb_we_o), 32'd0);
        check({tag, "_addr"},  bus_if.glb_addr_o, 32'd0);
        check({tag, "_wdata"}, bus_if.glb_wdata_o, 32'd0);
        check({tag, "_pop"},   bus_if.opsum_pop_en, 32'd0);
        check({tag, "_done"},  32'(wb_done_o), 32'd0);
    endtask

    initial begin
        bus_if.glb_ready_i = 1'b1;
        clear_all();
        repeat (3) step();
        check_outputs_zero("rst");
        rst_n = 1'b1;
        step();
        check_outputs_zero("idle");

        // T1: single column, four words
        base_i = 32'h1000; tile_n_i = 16'd4; oc_real_i = 7'd1;
        load(0, 4, 32'hA0);
        snap();
        pulse_start();
        lat = 1;
        wait_done(100, lat);
        check("t1_done", 32'(wb_done_o), 32'd1);
        check("t1_latency", lat, 32'd18);
        repeat (3) step();
        check("t1_done_cnt", done_cnt - snap_done, 32'd1);
        check("t1_nwr", wr_n - snap_wr, 32'd4);
        check_wr("t1", 0, 32'h1000, 32'hA0);
        check_wr("t1", 1, 32'h1004, 32'hA1);
        check_wr("t1", 2, 32'h1008, 32'hA2);
        check_wr("t1", 3, 32'h100C, 32'hA3);
        check("t1_pops0", pops[0] - pop_snap[0], 32'd4);

        // T2: three columns round-robin, all FIFOs full
        clear_all();
        for (int c = 0; c < NUM_COL; c++) load(c, 4, 32'hB000 + 32'(c) * 32'd16);
        base_i = 32'h2000; tile_n_i = 16'd2; oc_real_i = 7'd3;
        snap();
        pulse_start();
        lat = 1;
        wait_done(200, lat);
        check("t2_done", 32'(wb_done_o), 32'd1);
        repeat (2) step();
        check("t2_nwr", wr_n - snap_wr, 32'd6);
        check_wr("t2", 0, 32'h2000, 32'hB000);
        check_wr("t2", 1, 32'h2008, 32'hB010);
        check_wr("t2", 2, 32'h2010, 32'hB020);
        check_wr("t2", 3, 32'h2004, 32'hB001);
        check_wr("t2", 4, 32'h200C, 32'hB011);
        check_wr("t2", 5, 32'h2014, 32'hB021);
        for (int c = 0; c < 3; c++) check($sformatf("t2_pops%0d", c), pops[c] - pop_snap[c], 32'd2);
        sum = 0;
        for (int c = 3; c < NUM_COL; c++) sum = sum + (pops[c] - pop_snap[c]);
        check("t2_inactive_pops", sum, 32'd0);

        // T3: backpressure holds the write stable
        clear_all();
        bus_if.glb_ready_i = 1'b0;
        load(0, 2, 32'h55);
        base_i = 32'h3000; tile_n_i = 16'd2; oc_real_i = 7'd1;
        snap();
        pulse_start();
        wait_we(50);
        check("t3_we_seen", 32'(bus_if.glb_we_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_we", 32'(bus_if.glb_we_o), 32'd1);
            check("t3_hold_addr", bus_if.glb_addr_o, 32'h3000);
            check("t3_hold_data", bus_if.glb_wdata_o, 32'h55);
            check("t3_hold_pop", bus_if.opsum_pop_en, 32'd0);
            step();
        end
        check("t3_stall_pops", pops[0] - pop_snap[0], 32'd1);
        check("t3_stall_nwr", wr_n - snap_wr, 32'd0);
        bus_if.glb_ready_i = 1'b1;
        lat = 0;
        wait_done(100, lat);
        check("t3_done", 32'(wb_done_o), 32'd1);
        repeat (2) step();
        check("t3_nwr", wr_n - snap_wr, 32'd2);
        check_wr("t3", 0, 32'h3000, 32'h55);
        check_wr("t3", 1, 32'h3004, 32'h56);

        // T4: empty active column and non-empty inactive column
        clear_all();
        load(0, 2, 32'hC0);
        load(5, 3, 32'hF5);
        base_i = 32'h4000; tile_n_i = 16'd2; oc_real_i = 7'd2;
        snap();
        pulse_start();
        repeat (3) step();
        base_i = 32'h9000; tile_n_i = 16'd5; oc_real_i = 7'd8;
        pulse_start();
        base_i = 32'h4000; tile_n_i = 16'd2; oc_real_i = 7'd2;
        repeat (15) step();
        check("t4_win_pops1", pops[1] - pop_snap[1], 32'd0);
        check("t4_win_pops5", pops[5] - pop_snap[5], 32'd0);
        check("t4_win_pops0", pops[0] - pop_snap[0], 32'd2);
        check("t4_win_done", done_cnt - snap_done, 32'd0);
        check("t4_win_nwr", wr_n - snap_wr, 32'd2);
        check_wr("t4", 0, 32'h4000, 32'hC0);
        check_wr("t4", 1, 32'h4004, 32'hC1);
        load(1, 2, 32'hD0);
        lat = 0;
        wait_done(100, lat);
        check("t4_done", 32'(wb_done_o), 32'd1);
        repeat (2) step();
        check("t4_nwr", wr_n - snap_wr, 32'd4);
        check_wr("t4", 2, 32'h4008, 32'hD0);
        check_wr("t4", 3, 32'h400C, 32'hD1);
        check("t4_pops1", pops[1] - pop_snap[1], 32'd2);
        check("t4_pops5", pops[5] - pop_snap[5], 32'd0);
        check("t4_done_cnt", done_cnt - snap_done, 32'd1);

        // T5: degenerate starts finish immediately
        clear_all();
        for (int c = 0; c < 3; c++) load(c, 2, 32'hE0);
        base_i = 32'h7000; tile_n_i = 16'd0; oc_real_i = 7'd3;
        snap();
        pulse_start();
        lat = 1;
        wait_done(20, lat);
        check("t5a_done", 32'(wb_done_o), 32'd1);
        check("t5a_latency", lat, 32'd2);
        repeat (3) step();
        tile_n_i = 16'd5; oc_real_i = 7'd0;
        pulse_start();
        lat = 1;
        wait_done(20, lat);
        check("t5b_done", 32'(wb_done_o), 32'd1);
        check("t5b_latency", lat, 32'd2);
        repeat (3) step();
        check("t5_nwr", wr_n - snap_wr, 32'd0);
        sum = 0;
        for (int c = 0; c < NUM_COL; c++) sum = sum + (pops[c] - pop_snap[c]);
        check("t5_pops", sum, 32'd0);
        check("t5_done_cnt", done_cnt - snap_done, 32'd2);

        // T6: reset during a held write, then restart
        clear_all();
        bus_if.glb_ready_i = 1'b0;
        load(0, 3, 32'h70);
        base_i = 32'h5000; tile_n_i = 16'd3; oc_real_i = 7'd1;
        snap();
        pulse_start();
        wait_we(50);
        check("t6_we_seen", 32'(bus_if.glb_we_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        repeat (2) begin
            step();
            check("t6_rst_pop", bus_if.opsum_pop_en, 32'd0);
        end
        rst_n = 1'b1;
        step();
        clear_all();
        bus_if.glb_ready_i = 1'b1;
        load(0, 1, 32'h99);
        base_i = 32'h6000; tile_n_i = 16'd1; oc_real_i = 7'd1;
        pulse_start();
        lat = 1;
        wait_done(50, lat);
        check("t6_done", 32'(wb_done_o), 32'd1);
        repeat (2) step();
        check("t6_nwr", wr_n - snap_wr, 32'd1);
        check_wr("t6", 0, 32'h6000, 32'h99);
        check("t6_done_cnt", done_cnt - snap_done, 32'd1);

        check("bad_pop_cnt", bad_pop, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/opsum_writeback_controller.md
Name: opsum_writeback_controller

Overview:
Drains finished output partial sums from the 32 per-column opsum FIFOs of conv_unit and writes them into the GLB opsum region. It is the reader side of the opsum FIFO interface: the conv_unit pushes into these FIFOs, and this block pops them. Columns are serviced round-robin, with one 32-bit GLB write per popped entry. The block is started per pass by the controller, next to token_engine.

Parameters:
NUM_COL, 32, number of opsum FIFO columns
DATA_W, 32, opsum word width / GLB write data width
CNT_W, 16, per-column entry counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wb_start_i  input  1  one-cycle start pulse, accepted only in IDLE
wb_done_o  output  1  one-cycle pulse when all active columns are drained
opsum_GLB_base_addr  input  32  byte base address of opsum region, latched at start
tile_n_i  input  CNT_W  entries to drain per column, latched at start
OC_real_i  input  7  active columns (0..32), latched at start
opsum_fifo_empty  input  NUM_COL  per-column FIFO empty flags
opsum_pop_en  output  NUM_COL  per-column pop strobe, at most one bit high
opsum_pop_data  input  NUM_COL x DATA_W  FIFO head data, valid the cycle after pop
glb_we_o  output  1  GLB write request
glb_addr_o  output  32  GLB byte address
glb_wdata_o  output  DATA_W  GLB write data
glb_ready_i  input  1  GLB accepts write when glb_we_o and glb_ready_i are both high

Behaviour:
- Reset: state IDLE. wb_done_o, opsum_pop_en, glb_we_o, glb_addr_o, glb_wdata_o are 0. All column counters, the round-robin pointer and the latched config are 0.
- All outputs are registered (Moore).
- States: IDLE, SCAN, POP, CAP, WRITE, DONE.
- IDLE
  - On wb_start_i: latch base, tile_n, OC_real (values >32 clamp to 32), clear counters, set ptr=0.
  - If OC_real==0 or tile_n==0, go to DONE; otherwise go to SCAN.
- SCAN
  - Search columns in order ptr, ptr+1, … wrapping modulo OC_real.
  - A column c qualifies when c < OC_real, opsum_fifo_empty[c]==0 and cnt[c] < tile_n.
  - First qualifying column: latch sel=c, go to POP. None qualify: stay in SCAN.
- POP: opsum_pop_en = one-hot(sel) for exactly one cycle. Go to CAP.
- CAP
  - glb_wdata_o <= opsum_pop_data[sel].
  - glb_addr_o <= base + ((sel*tile_n + cnt[sel]) << 2), computed in 32-bit and wrapping modulo 2^32.
  - glb_we_o <= 1. Go to WRITE.
- WRITE
  - Hold glb_we_o, glb_addr_o and glb_wdata_o stable until glb_ready_i==1.
  - On the accept cycle: cnt[sel]++, ptr <= (sel+1) mod OC_real, glb_we_o <= 0.
  - Then go to DONE if every active column has cnt == tile_n, else SCAN.
- DONE: wb_done_o=1 for one cycle, then IDLE.
- Throughput: minimum 4 cycles per word (SCAN→POP→CAP→WRITE with ready high).
- Never pop a FIFO that is empty or whose column is >= OC_real. No pop is issued while WRITE is stalled.
- wb_start_i outside IDLE is ignored.
- Columns whose counter reached tile_n are never popped again, even if their FIFO is non-empty.
- Reset mid-operation returns to IDLE with all outputs 0. A partially held write is dropped, and no pop is issued in the reset cycle.

Test Plan:
1. OC_real=1, tile_n=4, col0 holds 0xA0..0xA3, base=0x1000, ready=1 → writes (0x1000,0xA0), (0x1004,0xA1), (0x1008,0xA2), (0x100C,0xA3), one pop each; wb_done_o pulses once.
2. OC_real=3, tile_n=2, all FIFOs full → service order 0,1,2,0,1,2. Col1 entries land at base+8 and base+12; col2 entries land at base+16 and base+20.
3. Backpressure: glb_ready_i low for 5 cycles during a WRITE → glb_we_o, glb_addr_o and glb_wdata_o stay constant, opsum_pop_en stays 0, and exactly one counter increment occurs on accept.
4. Empty and inactive columns: OC_real=2; col1 empty for 20 cycles; col5 non-empty → col1 and col5 are never popped during that window, and col5 is never popped at all. Col0 drains first; col1 is serviced once it becomes non-empty; done follows.
5. tile_n=0 or OC_real=0 with start → wb_done_o 2 cycles after start, no glb_we_o, no pops.
6. Assert rst_n low mid-WRITE, then restart with OC_real=1, tile_n=1 → all outputs 0 during reset; the restart writes base+0 correctly and pulses done.
